regfile_dumper: RTL and testbench

Read-side initiator for the 16 × 16-bit register file. On a start command it drives the register file's read address, captures each read word, and streams a contiguous, wrapping range of registers out over a valid/ready handshake. It sits between the register file read port 1 (`ra1`/`rd1`) and a debug/trace consumer, and is used for state dumps and for self-checking benches.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile.sv | 26 ++
 rtl/regfile_dumper.sv | 95 +++++++++
 tb/tb_regfile_dumper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16 x 16-bit register file and its dump engine.
package regfile_pkg;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NREGS = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/regfile.sv
// 16 x 16-bit register file: one synchronous write port, two combinational read ports.
module regfile
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] regs [NREGS];

  // NOTE: the storage array is deliberately not reset; its contents are defined by writes
  // only, which keeps it mappable onto RAM or flop arrays without a reset fan-out.
  always_ff @(posedge clk) begin
    if (we) regs[wa] <= wd;
  end

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/regfile_dumper.sv
// Streams a contiguous, wrapping range of registers out of the register file
// over a valid/ready handshake, one word per FETCH/SEND pair.
module regfile_dumper #(
  parameter int AW    = regfile_pkg::AW,
  parameter int DW    = regfile_pkg::DW,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW:0]   count,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  import regfile_pkg::*;

  dump_state_t   state;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;

  // The address is presented in every state; the register file read is only captured in FETCH.
  assign ra = addr;

  // NOTE: every state register uses non-blocking assignment so all of them update together
  // from the values sampled at the same edge; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr      <= first_addr;
            remaining <= count;
            busy      <= 1'b1;
            if (count != '0) begin
              state <= FETCH;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end

        FETCH: begin
          out_data  <= rd;
          out_addr  <= addr;
          out_last  <= (remaining == (AW+1)'(1));
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              addr  <= (addr == AW'(NREGS - 1)) ? '0 : addr + AW'(1);
              state <= FETCH;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench: real regfile plus dumper, with a memory-image model that
// predicts every beat, the done pulse and the busy window.
module tb_regfile_dumper;
  import regfile_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [AW-1:0] ra2 = '0;
  logic [DW-1:0] rd2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model [NREGS];

  always #5 clk = ~clk;

  regfile u_rf (
    .clk (clk), .we (we), .wa (wa), .wd (wd),
    .ra1 (ra), .rd1 (rd), .ra2 (ra2), .rd2 (rd2)
  );

  regfile_dumper #(.AW(AW), .DW(DW), .NREGS(NREGS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .ra         (ra),
    .rd         (rd),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
    model[a] = d;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"},  out_last,  1'b0);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_done"},  done,      1'b0);
    check({tag, "_data"},  out_data,  '0);
    check({tag, "_addr"},  out_addr,  '0);
    check({tag, "_ra"},    ra,        '0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 5 valid cycles on the second beat.
  task automatic run_dump(input logic [AW-1:0] first, input logic [AW:0] cnt, input int mode,
                          input bit poke_start, input bit snap);
    logic [AW-1:0] ea [NREGS];
    logic [DW-1:0] ed [NREGS];
    int beat   = 0;
    int done_j = -1;
    int stall  = 0;
    bit r;
    bit snapped = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      ea[i] = first + AW'(i);
      ed[i] = model[ea[i]];
    end
    @(negedge clk);
    start = 1'b1; first_addr = first; count = cnt;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 400; j++) begin
      if (j > 0) @(negedge clk);
      start = 1'b0;
      we    = 1'b0;
      if (poke_start && j == 3) begin
        start = 1'b1; first_addr = first + AW'(7); count = 5;
      end
      check("busy_during_dump", busy, 1'b1);
      if (out_valid) begin
        if (beat >= int'(cnt)) begin
          check("extra_beat", out_valid, 1'b0);
        end else begin
          check("beat_addr", out_addr, ea[beat]);
          check("beat_data", out_data, ed[beat]);
          check("beat_last", out_last, (beat == int'(cnt) - 1));
        end
      end
      if (snap && !snapped && out_valid && out_addr == AW'(5)) begin
        we = 1'b1; wa = 5; wd = 16'h1234;
        model[5] = 16'h1234;
        snapped = 1'b1;
      end
      if (done) begin
        check("done_beats", beat, cnt);
        check("done_no_valid", out_valid, 1'b0);
        if (mode == 0) check("done_cycle", j, (cnt == 0) ? 0 : 2 * int'(cnt));
        done_j = j;
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && beat == 1 && stall < 5) begin
            r = 1'b0;
            stall++;
          end else begin
            r = 1'b1;
          end
        end
      endcase
      out_ready = r;
      if (out_valid && r) beat++;
    end
    if (done_j < 0) check("done_timeout", done_j, 0);
    @(negedge clk);
    start = 1'b0;
    we    = 1'b0;
    check("post_done_low", done, 1'b0);
    check("post_busy_low", busy, 1'b0);
    check("post_valid_low", out_valid, 1'b0);
    if (mode == 2) check("stall_cycles", stall, 5);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < NREGS; i++) write_reg(AW'(i), 16'hA000 + DW'(i));
    ra2 = 3;
    #1 check("rd2_port", rd2, 16'hA003);

    // full dump, wrap-around, backpressure, empty request
    run_dump(4'd0, 5'd16, 0, 1'b0, 1'b0);
    run_dump(4'd14, 5'd4, 0, 1'b0, 1'b0);
    run_dump(4'd0, 5'd4, 2, 1'b0, 1'b0);
    run_dump(4'd9, 5'd0, 0, 1'b0, 1'b0);

    // reset during SEND of the third beat
    @(negedge clk);
    out_ready = 1'b1; start = 1'b1; first_addr = 0; count = 8;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_valid", out_valid, 1'b1);
    check("rst_pre_addr", out_addr, 2);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("midrst");
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_done", done, 1'b0);
      check("midrst_idle", busy, 1'b0);
    end
    run_dump(4'd3, 5'd3, 0, 1'b0, 1'b0);

    // start while busy is ignored; write after the addr-5 fetch is not in the beat
    run_dump(4'd2, 5'd6, 0, 1'b1, 1'b1);
    run_dump(4'd5, 5'd1, 0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 3; k++) write_reg(AW'($urandom), DW'($urandom));
      run_dump(AW'($urandom), (AW+1)'($urandom_range(0, 16)), 1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
